// File: rtl/pc_unit_ras_pkg.sv
// rtl/pc_unit_ras_pkg.sv - shared encodings and defaults for the fetch PC unit
package pc_unit_ras_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'b00,
    PC_SRC_JMP = 2'b01,
    PC_SRC_BR  = 2'b10,
    PC_SRC_RET = 2'b11
  } pc_src_e;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_INSTR_BYTES = 2;
  localparam int DEF_RAS_DEPTH   = 4;

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_unit_ras_if.sv
// rtl/pc_unit_ras_if.sv - redirect control and status bundle for the fetch PC unit
interface pc_unit_ras_if
  import pc_unit_ras_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = ras_cnt_w(DEF_RAS_DEPTH)
);
  logic              stall;
  pc_src_e           pc_src;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] i_target;
  logic [ADDR_W-1:0] ret_addr_ext;
  logic              call;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;
  logic              align_fault;

  modport master (
    output stall, pc_src, j_target, i_target, ret_addr_ext, call, link_addr,
    input  pc, pc_next, ras_count, ras_empty, ras_full,
           ras_overflow, ras_underflow, align_fault
  );

  modport slave (
    input  stall, pc_src, j_target, i_target, ret_addr_ext, call, link_addr,
    output pc, pc_next, ras_count, ras_empty, ras_full,
           ras_overflow, ras_underflow, align_fault
  );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// rtl/pc_unit_ras_stack.sv - circular return-address stack; a push when full drops the oldest entry
module pc_unit_ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  assign top      = mem[ptr];
  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign overflow = push && full;

  // ptr always names the top slot; wrap-around overwrites the oldest entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr + PTR_W'(1)] <= din;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch program counter with stall, target alignment check and optional RAS
module pc_unit_ras
  import pc_unit_ras_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter bit                USE_RAS     = 1'b1,
  parameter int                RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  pc_unit_ras_if.slave bus
);
  localparam int                CNT_W      = ras_cnt_w(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] raw_target;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf_hit;
  logic              ras_hit;
  logic              push;
  logic              pop;
  logic              ovf_d;
  logic              unf_d;
  logic              flt_d;
  logic              ovf_q;
  logic              unf_q;
  logic              flt_q;

  always_comb begin
    ras_hit    = USE_RAS && !ras_empty;
    raw_target = bus.j_target;
    case (bus.pc_src)
      PC_SRC_JMP: raw_target = bus.j_target;
      PC_SRC_BR:  raw_target = bus.i_target;
      PC_SRC_RET: raw_target = ras_hit ? ras_top : bus.ret_addr_ext;
      default:    raw_target = bus.j_target;
    endcase
  end

  always_comb begin
    pc_next = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    flt_d   = 1'b0;
    if (!bus.stall) begin
      if (bus.pc_src == PC_SRC_SEQ) begin
        pc_next = pc_q + STEP;
      end else begin
        pc_next = raw_target & ALIGN_MASK;
        flt_d   = |(raw_target & ~ALIGN_MASK);
      end
      push  = (bus.pc_src == PC_SRC_JMP) && bus.call;
      pop   = (bus.pc_src == PC_SRC_RET) && ras_hit;
      ovf_d = push && ras_ovf_hit;
      unf_d = USE_RAS && (bus.pc_src == PC_SRC_RET) && ras_empty;
    end
  end

  generate
    if (USE_RAS) begin : g_ras
      pc_unit_ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .din      (bus.link_addr),
        .top      (ras_top),
        .count    (ras_count),
        .empty    (ras_empty),
        .full     (ras_full),
        .overflow (ras_ovf_hit)
      );
    end else begin : g_no_ras
      assign ras_top     = '0;
      assign ras_count   = '0;
      assign ras_empty   = 1'b1;
      assign ras_full    = 1'b0;
      assign ras_ovf_hit = 1'b0;
    end
  endgenerate

  // pc_next already holds pc_q during stall, so the register loads every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      flt_q <= flt_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_next       = pc_next;
  assign bus.ras_count     = ras_count;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
  assign bus.align_fault   = flt_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed scoreboard bench for pc_unit_ras
module tb_pc_unit_ras;
  import pc_unit_ras_pkg::*;

  localparam int AW = 16;
  localparam int CW = 3;

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        flt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_unit_ras_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  pc_unit_ras #(
    .ADDR_W(AW), .INSTR_BYTES(2), .RESET_PC(16'h0000), .USE_RAS(1'b1), .RAS_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk({e.tag, ".pc"},        32'(bus.pc),            32'(e.pc));
    chk({e.tag, ".count"},     32'(bus.ras_count),     32'(e.cnt));
    chk({e.tag, ".empty"},     32'(bus.ras_empty),     32'(e.cnt == 3'd0));
    chk({e.tag, ".full"},      32'(bus.ras_full),      32'(e.cnt == 3'd4));
    chk({e.tag, ".overflow"},  32'(bus.ras_overflow),  32'(e.ovf));
    chk({e.tag, ".underflow"}, 32'(bus.ras_underflow), 32'(e.unf));
    chk({e.tag, ".fault"},     32'(bus.align_fault),   32'(e.flt));
  endtask

  task automatic drive(input pc_src_e src, input logic [15:0] tgt, input logic cl,
                       input logic [15:0] link, input logic st, input logic [15:0] ext);
    bus.pc_src       = src;
    bus.j_target     = (src == PC_SRC_JMP) ? tgt : 16'h7770;
    bus.i_target     = (src == PC_SRC_BR)  ? tgt : 16'h5550;
    bus.call         = cl;
    bus.link_addr    = link;
    bus.stall        = st;
    bus.ret_addr_ext = ext;
  endtask

  task automatic step(input string tag, input pc_src_e src, input logic [15:0] tgt,
                      input logic cl, input logic [15:0] link, input logic st,
                      input logic [15:0] ext, input logic [15:0] epc, input logic [2:0] ecnt,
                      input logic eovf, input logic eunf, input logic eflt);
    exp_t e;
    drive(src, tgt, cl, link, st, ext);
    #1;
    chk({tag, ".pc_next"}, 32'(bus.pc_next), 32'(epc));
    sb.push_back('{tag: tag, pc: epc, cnt: ecnt, ovf: eovf, unf: eunf, flt: eflt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    drive(PC_SRC_SEQ, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    sb.push_back('{tag: "reset", pc: 16'h0000, cnt: 3'd0, ovf: 1'b0, unf: 1'b0, flt: 1'b0});
    e = sb.pop_front();
    check_out(e);
    @(posedge clk);
    #1;

    step("seq0", PC_SRC_SEQ, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0002, 3'd0, 1'b0, 1'b0, 1'b0);
    step("seq1", PC_SRC_SEQ, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0004, 3'd0, 1'b0, 1'b0, 1'b0);
    step("seq2", PC_SRC_SEQ, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0006, 3'd0, 1'b0, 1'b0, 1'b0);
    step("seq3", PC_SRC_SEQ, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0);
    step("br10", PC_SRC_BR, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0010, 3'd0, 1'b0, 1'b0, 1'b0);

    step("stall", PC_SRC_JMP, 16'h0100, 1'b1, 16'h0012, 1'b1, 16'h0, 16'h0010, 3'd0, 1'b0, 1'b0, 1'b0);

    step("call1", PC_SRC_JMP, 16'h0100, 1'b1, 16'h0012, 1'b0, 16'h0, 16'h0100, 3'd1, 1'b0, 1'b0, 1'b0);
    step("call2", PC_SRC_JMP, 16'h0200, 1'b1, 16'h0104, 1'b0, 16'h0, 16'h0200, 3'd2, 1'b0, 1'b0, 1'b0);
    step("ret1",  PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0EEE, 16'h0104, 3'd1, 1'b0, 1'b0, 1'b0);
    step("ret2",  PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0EEE, 16'h0012, 3'd0, 1'b0, 1'b0, 1'b0);

    step("br_call", PC_SRC_BR, 16'h0300, 1'b1, 16'h0555, 1'b0, 16'h0, 16'h0300, 3'd0, 1'b0, 1'b0, 1'b0);

    step("ov_c1", PC_SRC_JMP, 16'h0040, 1'b1, 16'h0002, 1'b0, 16'h0, 16'h0040, 3'd1, 1'b0, 1'b0, 1'b0);
    step("ov_c2", PC_SRC_JMP, 16'h0080, 1'b1, 16'h0004, 1'b0, 16'h0, 16'h0080, 3'd2, 1'b0, 1'b0, 1'b0);
    step("ov_c3", PC_SRC_JMP, 16'h00C0, 1'b1, 16'h0006, 1'b0, 16'h0, 16'h00C0, 3'd3, 1'b0, 1'b0, 1'b0);
    step("ov_c4", PC_SRC_JMP, 16'h0100, 1'b1, 16'h0008, 1'b0, 16'h0, 16'h0100, 3'd4, 1'b0, 1'b0, 1'b0);
    step("ov_c5", PC_SRC_JMP, 16'h0140, 1'b1, 16'h000A, 1'b0, 16'h0, 16'h0140, 3'd4, 1'b1, 1'b0, 1'b0);
    step("ov_r1", PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0EEE, 16'h000A, 3'd3, 1'b0, 1'b0, 1'b0);
    step("ov_r2", PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0EEE, 16'h0008, 3'd2, 1'b0, 1'b0, 1'b0);
    step("ov_r3", PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0EEE, 16'h0006, 3'd1, 1'b0, 1'b0, 1'b0);
    step("ov_r4", PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0EEE, 16'h0004, 3'd0, 1'b0, 1'b0, 1'b0);
    step("un_r5", PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0F00, 16'h0F00, 3'd0, 1'b0, 1'b1, 1'b0);

    step("br_mis", PC_SRC_BR, 16'h0033, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0032, 3'd0, 1'b0, 1'b0, 1'b1);
    step("br_top", PC_SRC_BR, 16'hFFFE, 1'b0, 16'h0, 1'b0, 16'h0, 16'hFFFE, 3'd0, 1'b0, 1'b0, 1'b0);
    step("wrap",   PC_SRC_SEQ, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

    step("pre_c1", PC_SRC_JMP, 16'h0400, 1'b1, 16'h0022, 1'b0, 16'h0, 16'h0400, 3'd1, 1'b0, 1'b0, 1'b0);
    step("pre_c2", PC_SRC_JMP, 16'h0500, 1'b1, 16'h0032, 1'b0, 16'h0, 16'h0500, 3'd2, 1'b0, 1'b0, 1'b0);
    step("pre_br", PC_SRC_BR, 16'h0601, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0600, 3'd2, 1'b0, 1'b0, 1'b1);

    drive(PC_SRC_SEQ, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    #2;
    reset = 1'b1;
    #1;
    sb.push_back('{tag: "mid_rst", pc: 16'h0000, cnt: 3'd0, ovf: 1'b0, unf: 1'b0, flt: 1'b0});
    e = sb.pop_front();
    check_out(e);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    step("post_ret", PC_SRC_RET, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0AA0, 16'h0AA0, 3'd0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
